// File: rtl/boss_pkg.sv
// rtl/boss_pkg.sv - shared boss motion constants and state type
package boss_pkg;

  localparam logic [11:0] SPAWN_X  = 12'd824;
  localparam logic [11:0] GROUND_Y = 12'd600;
  localparam logic [11:0] X_MIN    = 12'd106;
  localparam logic [11:0] X_MAX    = 12'd918;

  localparam logic [4:0] WALK_SPEED = 5'd2;
  localparam logic [4:0] AIR_SPEED  = 5'd3;
  localparam logic [4:0] JUMP_VEL   = 5'd12;

  localparam int WALK_FRAMES     = 120;
  localparam int COOLDOWN_FRAMES = 60;
  localparam int DEADBAND        = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WALK,
    ST_JUMP,
    ST_FALL,
    ST_COOLDOWN
  } boss_state_t;

  function automatic logic is_airborne(boss_state_t s);
    return (s == ST_JUMP) || (s == ST_FALL);
  endfunction

endpackage

// File: rtl/boss_move_if.sv
// rtl/boss_move_if.sv - game-side inputs and renderer-side outputs of the boss mover
interface boss_move_if;

  logic [1:0]  game_active;
  logic        frame_tick;
  logic [11:0] player_x;
  logic [6:0]  boss_hp;
  logic [11:0] boss_x;
  logic [11:0] boss_y;
  logic        boss_airborne;

  modport master (
    output game_active, frame_tick, player_x, boss_hp,
    input  boss_x, boss_y, boss_airborne
  );

  modport slave (
    input  game_active, frame_tick, player_x, boss_hp,
    output boss_x, boss_y, boss_airborne
  );

endinterface

// File: rtl/boss_step_x.sv
// rtl/boss_step_x.sv - one horizontal step toward a target with deadband and arena clamp
module boss_step_x
  import boss_pkg::*;
(
  input  logic [11:0] cur_x,
  input  logic [11:0] target_x,
  input  logic [4:0]  speed,
  output logic [11:0] next_x
);

  logic [12:0]        cur_u;
  logic [12:0]        tgt_u;
  logic signed [12:0] stepped;

  // Deadband compares are unsigned in 13 bits so player_x+4 cannot wrap.
  always_comb begin
    cur_u   = {1'b0, cur_x};
    tgt_u   = {1'b0, target_x};
    stepped = $signed(cur_u);
    if (tgt_u > cur_u + 13'(DEADBAND)) begin
      stepped = $signed(cur_u) + $signed({8'b0, speed});
    end else if (tgt_u + 13'(DEADBAND) < cur_u) begin
      stepped = $signed(cur_u) - $signed({8'b0, speed});
    end

    if (stepped < $signed({1'b0, X_MIN})) begin
      next_x = X_MIN;
    end else if (stepped > $signed({1'b0, X_MAX})) begin
      next_x = X_MAX;
    end else begin
      next_x = 12'(stepped);
    end
  end

endmodule

// File: rtl/boss_move.sv
// rtl/boss_move.sv - boss walk/jump/fall/cooldown motion, advanced once per frame tick
module boss_move
  import boss_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  boss_move_if.slave  bus
);

  boss_state_t state_q, state_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [4:0]  vel_q, vel_d;
  logic [6:0]  walk_q, walk_d;
  logic [5:0]  cd_q, cd_d;
  logic        air_q;
  logic [4:0]  step_speed;
  logic [11:0] step_x;

  assign step_speed = (state_q == ST_WALK) ? WALK_SPEED : AIR_SPEED;

  boss_step_x u_step (
    .cur_x    (x_q),
    .target_x (bus.player_x),
    .speed    (step_speed),
    .next_x   (step_x)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= SPAWN_X;
      y_q     <= GROUND_Y;
      vel_q   <= '0;
      walk_q  <= '0;
      cd_q    <= '0;
      air_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      walk_q  <= walk_d;
      cd_q    <= cd_d;
      air_q   <= is_airborne(state_d);
    end
  end

  // Leaving the game beats everything, then a dead boss freezes, then the tick advances.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    walk_d  = walk_q;
    cd_d    = cd_q;
    if (bus.game_active != 2'd1) begin
      state_d = ST_IDLE;
      x_d     = SPAWN_X;
      y_d     = GROUND_Y;
      vel_d   = '0;
      walk_d  = '0;
      cd_d    = '0;
    end else if (bus.boss_hp != '0 && bus.frame_tick) begin
      case (state_q)
        ST_IDLE: state_d = ST_WALK;
        ST_WALK: begin
          x_d = step_x;
          if (walk_q == 7'(WALK_FRAMES - 1)) begin
            walk_d  = '0;
            vel_d   = JUMP_VEL;
            state_d = ST_JUMP;
          end else begin
            walk_d = walk_q + 7'd1;
          end
        end
        ST_JUMP: begin
          x_d   = step_x;
          y_d   = y_q - {7'b0, vel_q};
          vel_d = (vel_q == '0) ? '0 : vel_q - 5'd1;
          if (vel_q <= 5'd1) state_d = ST_FALL;
        end
        ST_FALL: begin
          x_d = step_x;
          if (({1'b0, y_q} + {8'b0, vel_q}) >= {1'b0, GROUND_Y}) begin
            y_d     = GROUND_Y;
            vel_d   = '0;
            cd_d    = '0;
            state_d = ST_COOLDOWN;
          end else begin
            y_d   = y_q + {7'b0, vel_q};
            vel_d = (vel_q >= JUMP_VEL) ? JUMP_VEL : vel_q + 5'd1;
          end
        end
        ST_COOLDOWN: begin
          if (cd_q == 6'(COOLDOWN_FRAMES - 1)) begin
            cd_d    = '0;
            walk_d  = '0;
            state_d = ST_WALK;
          end else begin
            cd_d = cd_q + 6'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.boss_x        = x_q;
  assign bus.boss_y        = y_q;
  assign bus.boss_airborne = air_q;

endmodule

// File: tb/tb_boss_move.sv
// tb/tb_boss_move.sv - scoreboard bench for boss_move against a per-frame motion model
module tb_boss_move;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  boss_move_if bus_if ();

  boss_move dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    int x;
    int y;
    bit air;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  int r, ga, tk, px, hp;
  string m_phase;
  int m_x, m_y, m_vel, m_walk, m_cd;

  function automatic int toward(int x, int tgt, int sp);
    int n;
    n = x;
    if (tgt > x + 4) n = x + sp;
    else if (tgt + 4 < x) n = x - sp;
    if (n < 106) n = 106;
    if (n > 918) n = 918;
    return n;
  endfunction

  task automatic model_update();
    if (r != 0 || ga != 1) begin
      m_phase = "idle"; m_x = 824; m_y = 600; m_vel = 0; m_walk = 0; m_cd = 0;
    end else if (hp != 0 && tk != 0) begin
      if (m_phase == "idle") begin
        m_phase = "walk";
      end else if (m_phase == "walk") begin
        m_x = toward(m_x, px, 2);
        m_walk++;
        if (m_walk == 120) begin m_walk = 0; m_vel = 12; m_phase = "up"; end
      end else if (m_phase == "up") begin
        m_x = toward(m_x, px, 3);
        m_y = m_y - m_vel;
        m_vel--;
        if (m_vel == 0) m_phase = "down";
      end else if (m_phase == "down") begin
        m_x = toward(m_x, px, 3);
        if (m_y + m_vel >= 600) begin
          m_y = 600; m_vel = 0; m_cd = 0; m_phase = "rest";
        end else begin
          m_y = m_y + m_vel;
          m_vel = (m_vel + 1 > 12) ? 12 : m_vel + 1;
        end
      end else begin
        m_cd++;
        if (m_cd == 60) begin m_cd = 0; m_walk = 0; m_phase = "walk"; end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    rst = (r != 0);
    bus_if.game_active = 2'(ga);
    bus_if.frame_tick  = (tk != 0);
    bus_if.player_x    = 12'(px);
    bus_if.boss_hp     = 7'(hp);
    model_update();
    e.x = m_x;
    e.y = m_y;
    e.air = (m_phase == "up") || (m_phase == "down");
    exp_q.push_back(e);
  endtask

  task automatic frame();
    tk = 1; step();
    tk = 0; step();
  endtask

  task automatic check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus_if.boss_x !== 12'(e.x) || bus_if.boss_y !== 12'(e.y) || bus_if.boss_airborne !== e.air) begin
          errors++;
          $display("FAIL scoreboard t=%0t x=%0d/%0d y=%0d/%0d air=%0d/%0d (actual/required)", $time,
                   bus_if.boss_x, e.x, bus_if.boss_y, e.y, bus_if.boss_airborne, e.air);
        end
      end
    end
  end

  initial begin
    int min_x;
    int fx;
    int guard;
    r = 1; ga = 0; tk = 0; px = 824; hp = 5;
    step(); step();
    check("rst_x", bus_if.boss_x, 824);
    check("rst_y", bus_if.boss_y, 600);
    check("rst_air", bus_if.boss_airborne, 0);

    r = 0; ga = 1; frame();
    check("enter_walk_x", bus_if.boss_x, 824);
    check("enter_walk_air", bus_if.boss_airborne, 0);
    px = 100;
    repeat (10) frame();
    check("walk10_x", bus_if.boss_x, 804);
    min_x = 4095;
    repeat (500) begin
      frame();
      if (int'(bus_if.boss_x) < min_x) min_x = int'(bus_if.boss_x);
    end
    check("x_floor_min", min_x, 106);
    check("x_floor_end", bus_if.boss_x, 106);

    ga = 0; step(); ga = 1; px = 824;
    frame();
    repeat (119) frame();
    check("walk119_air", bus_if.boss_airborne, 0);
    frame();
    check("jump_air", bus_if.boss_airborne, 1);
    repeat (12) frame();
    check("apex_y", bus_if.boss_y, 522);
    check("apex_air", bus_if.boss_airborne, 1);
    repeat (12) frame();
    check("fall12_y", bus_if.boss_y, 588);
    frame();
    check("land_y", bus_if.boss_y, 600);
    check("land_air", bus_if.boss_airborne, 0);
    px = 4000;
    repeat (60) frame();
    check("cooldown_x", bus_if.boss_x, 824);
    frame();
    check("cooldown_exit_x", bus_if.boss_x, 826);

    ga = 0; step(); ga = 1; px = 100;
    frame();
    repeat (137) frame();
    check("fall5_y", bus_if.boss_y, 532);
    ga = 2; tk = 0; step(); step();
    check("drop_x", bus_if.boss_x, 824);
    check("drop_y", bus_if.boss_y, 600);
    check("drop_air", bus_if.boss_airborne, 0);

    ga = 1; frame(); repeat (5) frame();
    ga = 3; tk = 1; step(); tk = 0; step();
    check("drop_tick_x", bus_if.boss_x, 824);
    ga = 1; frame();
    check("regain_idle_x", bus_if.boss_x, 824);

    ga = 0; step(); ga = 1; px = int'($urandom_range(0, 4095));
    frame();
    repeat (123) frame();
    fx = m_x;
    hp = 0;
    repeat (20) frame();
    check("freeze_x", bus_if.boss_x, fx);
    check("freeze_y", bus_if.boss_y, 567);
    hp = 5; frame();
    check("resume_y", bus_if.boss_y, 558);

    ga = 0; step(); ga = 1;
    frame(); repeat (122) frame();
    r = 1; step(); r = 0; step();
    check("rst_jump_y", bus_if.boss_y, 600);
    check("rst_jump_x", bus_if.boss_x, 824);
    frame(); frame();
    check("rst_no_vel_y", bus_if.boss_y, 600);

    repeat (3000) begin
      r  = ($urandom_range(0, 999) == 0) ? 1 : 0;
      ga = ($urandom_range(0, 299) == 0) ? int'($urandom_range(0, 3)) : 1;
      tk = int'($urandom_range(0, 1));
      hp = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, 127));
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0) px = int'($urandom_range(0, 4095));
        else px = m_x + int'($urandom_range(0, 12)) - 6;
      end
      step();
    end

    r = 0; ga = 0; tk = 0; step(); step();
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
